// File: rtl/median_window_fetch_if.sv
// Window-fetch bus: image RAM read port plus the window handshake
// towards the 3x3 median stage.
interface median_window_fetch_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0]  mem_addr;
  logic [PIX_W-1:0]   mem_data;
  logic               win_valid;
  logic               win_ready;
  logic [9*PIX_W-1:0] win_data;
  logic [6:0]         win_row;
  logic [6:0]         win_col;

  // Fetch side: reads the RAM and produces windows.
  modport master (
    output mem_addr,
    input  mem_data,
    output win_valid,
    input  win_ready,
    output win_data,
    output win_row,
    output win_col
  );

  // RAM and median-stage side.
  modport slave (
    input  mem_addr,
    output mem_data,
    input  win_valid,
    output win_ready,
    input  win_data,
    input  win_row,
    input  win_col
  );
endinterface

// File: rtl/median_window_fetch.sv
// 3x3 window fetcher for the median stage. Scans the image in raster order
// out of a synchronous-read RAM, keeps the two previous rows in line
// buffers and presents each complete window over a valid/ready handshake.
// Optional build macro WIN_STRIDE3_EN: emit only windows whose top-left
// corner row and column are multiples of 3 (non-overlapping tiling); the
// whole frame is still read.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start
// S_READ  | mem_addr driven for pixel (y, x)
// S_SHIFT | mem_data captured into window and line buffers
// S_OUT   | window presented, waiting for win_ready
// S_DONE  | one-cycle done pulse, then back to idle
module median_window_fetch #(
  parameter int IMG_W  = 100,
  parameter int IMG_H  = 100,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  median_window_fetch_if.master bus
);

  localparam logic [6:0] X_LAST = 7'(IMG_W - 1);
  localparam logic [6:0] Y_LAST = 7'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_SHIFT,
    S_OUT,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [6:0]        x, y;
  logic [ADDR_W-1:0] addr;
  logic [PIX_W-1:0]  lb0 [IMG_W];
  logic [PIX_W-1:0]  lb1 [IMG_W];
  logic [PIX_W-1:0]  win [9];

  logic last_pix;
  logic sel;
  logic in_win;
  logic win_valid_i;
  logic do_clear;
  logic do_shift;
  logic do_adv;

  assign last_pix = (x == X_LAST) && (y == Y_LAST);

`ifdef WIN_STRIDE3_EN
  // x mod 3 and y mod 3, tracked incrementally to avoid a divider.
  logic [1:0] xm, ym;

  // Top-left (y-2, x-2) is a multiple of 3 exactly when x and y are 2 mod 3.
  assign sel = (xm == 2'd2) && (ym == 2'd2);

  // Phase counters follow the raster position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xm <= 2'd0;
      ym <= 2'd0;
    end else if (do_clear) begin
      xm <= 2'd0;
      ym <= 2'd0;
    end else if (do_adv) begin
      if (x == X_LAST) begin
        xm <= 2'd0;
        ym <= (ym == 2'd2) ? 2'd0 : ym + 2'd1;
      end else begin
        xm <= (xm == 2'd2) ? 2'd0 : xm + 2'd1;
      end
    end
  end
`else
  assign sel = 1'b1;
`endif

  // Stale columns after a row wrap are never emitted because of x >= 2.
  assign in_win = (x >= 7'd2) && (y >= 7'd2) && sel;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode and per-state strobes.
  always_comb begin
    state_nx    = state;
    busy        = 1'b0;
    done        = 1'b0;
    win_valid_i = 1'b0;
    do_clear    = 1'b0;
    do_shift    = 1'b0;
    do_adv      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          do_clear = 1'b1;
          state_nx = S_READ;
        end
      end
      S_READ: begin
        busy     = 1'b1;
        state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        busy     = 1'b1;
        do_shift = 1'b1;
        if (in_win) begin
          state_nx = S_OUT;
        end else if (last_pix) begin
          state_nx = S_DONE;
        end else begin
          do_adv   = 1'b1;
          state_nx = S_READ;
        end
      end
      S_OUT: begin
        busy        = 1'b1;
        win_valid_i = 1'b1;
        if (bus.win_ready) begin
          if (last_pix) begin
            state_nx = S_DONE;
          end else begin
            do_adv   = 1'b1;
            state_nx = S_READ;
          end
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Raster position and RAM address advance together; the address is kept
  // as its own counter so no y*IMG_W multiply is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x    <= 7'd0;
      y    <= 7'd0;
      addr <= '0;
    end else if (do_clear) begin
      x    <= 7'd0;
      y    <= 7'd0;
      addr <= '0;
    end else if (do_adv) begin
      addr <= addr + ADDR_ONE;
      if (x == X_LAST) begin
        x <= 7'd0;
        y <= y + 7'd1;
      end else begin
        x <= x + 7'd1;
      end
    end
  end

  // Window shift register: columns move left, new column enters on the right.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else if (do_shift) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= lb0[x];
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= lb1[x];
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= bus.mem_data;
    end
  end

  // Line buffers: lb0 holds row y-2, lb1 row y-1; no reset since every
  // frame rewrites a column before it is read.
  always_ff @(posedge clk) begin
    if (do_shift) begin
      lb0[x] <= lb1[x];
      lb1[x] <= bus.mem_data;
    end
  end

  assign bus.mem_addr  = addr;
  assign bus.win_valid = win_valid_i;
  assign bus.win_data  = {win[8], win[7], win[6], win[5], win[4],
                          win[3], win[2], win[1], win[0]};
  assign bus.win_row   = win_valid_i ? (y - 7'd1) : 7'd0;
  assign bus.win_col   = win_valid_i ? (x - 7'd1) : 7'd0;

endmodule

// File: tb/tb_median_window_fetch.sv
// Scoreboard bench for median_window_fetch: a reference model derives every
// expected window straight from the image array; a monitor compares each
// accepted window and checks stall stability, done and busy timing.
module tb_median_window_fetch;

  localparam int IMG_W = 100;
  localparam int IMG_H = 100;
  localparam int NPIX  = IMG_W * IMG_H;
`ifdef WIN_STRIDE3_EN
  localparam int STRIDE   = 3;
  localparam int EXP_WIN  = 1089;
  localparam int EXP_BUSY = 21089;
  localparam int LAST_C   = 97;
`else
  localparam int STRIDE   = 1;
  localparam int EXP_WIN  = 9604;
  localparam int EXP_BUSY = 29604;
  localparam int LAST_C   = 98;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done;

  median_window_fetch_if #(.PIX_W(8), .ADDR_W(14)) bus ();

  median_window_fetch dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] img [NPIX];

  // Synchronous-read image RAM, one cycle latency.
  always @(posedge clk) bus.mem_data <= img[bus.mem_addr];

  typedef struct {
    logic [71:0] data;
    int          row;
    int          col;
  } win_t;

  win_t exp_q[$];

  int n_checks = 0, n_pass = 0;
  int cyc = 0;
  int busy_cyc, done_cnt, accepted, first_lat, start_cyc, last_row, last_col;
  bit seen_first, seen_acc, rand_ready, spike_mode, done_prev, hold_v;
  logic [71:0] hold_d, first_data;
  logic [6:0]  hold_r, hold_c, first_row, first_col;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: every window whose top-left corner is on the stride
  // grid, in raster order of that corner.
  task automatic build_expected();
    exp_q.delete();
    for (int r = 0; r + 2 < IMG_H; r += STRIDE)
      for (int c = 0; c + 2 < IMG_W; c += STRIDE) begin
        win_t w;
        w.data = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            w.data[(i*3+j)*8 +: 8] = img[(r+i)*IMG_W + c + j];
        w.row = r + 1;
        w.col = c + 1;
        exp_q.push_back(w);
      end
  endtask

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (rst) begin
      hold_v    = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        chk("done_width", 72'(done_prev), 72'd0);
      end
      done_prev = done;
      if (bus.win_valid && !seen_first) begin
        seen_first = 1'b1;
        first_lat  = cyc - start_cyc;
      end
      if (hold_v) begin
        chk("stall_valid", 72'(bus.win_valid), 72'd1);
        chk("stall_data", bus.win_data, hold_d);
        chk("stall_row", 72'(bus.win_row), 72'(hold_r));
        chk("stall_col", 72'(bus.win_col), 72'(hold_c));
      end
      hold_v = bus.win_valid && !bus.win_ready;
      hold_d = bus.win_data;
      hold_r = bus.win_row;
      hold_c = bus.win_col;
      if (bus.win_valid && bus.win_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_window", 72'(exp_q.size()), 72'd1);
        end else begin
          win_t w;
          w = exp_q.pop_front();
          chk("win_data", bus.win_data, w.data);
          chk("win_row", 72'(bus.win_row), 72'(w.row));
          chk("win_col", 72'(bus.win_col), 72'(w.col));
        end
        if (!seen_acc) begin
          seen_acc   = 1'b1;
          first_data = bus.win_data;
          first_row  = bus.win_row;
          first_col  = bus.win_col;
        end
        if (spike_mode && bus.win_row == 7'd50 && bus.win_col == 7'd50)
          chk("spike_p4", 72'(bus.win_data[39:32]), 72'hFF);
        if (spike_mode && bus.win_row == 7'd51 && bus.win_col == 7'd51)
          chk("spike_p0", 72'(bus.win_data[7:0]), 72'hFF);
        accepted++;
        last_row = bus.win_row;
        last_col = bus.win_col;
      end
    end
  end

  // Consumer: always ready, or ready about 30% of cycles.
  initial begin
    bus.win_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.win_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  task automatic start_frame();
    build_expected();
    busy_cyc   = 0;
    done_cnt   = 0;
    accepted   = 0;
    seen_first = 1'b0;
    seen_acc   = 1'b0;
    first_lat  = -1;
    @(posedge clk);
    #1;
    start     = 1'b1;
    start_cyc = cyc + 1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 60000) begin
      @(posedge clk);
      n++;
    end
    chk("done_seen", 72'(done_cnt != 0), 72'd1);
    repeat (5) @(posedge clk);
  endtask

  task automatic wait_accepted(input int target);
    int n = 0;
    while (accepted < target && n < 30000) begin
      @(posedge clk);
      n++;
    end
    chk("accept_progress", 72'(accepted >= target), 72'd1);
  endtask

  task automatic abort_frame();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_valid", 72'(bus.win_valid), 72'd0);
    chk("abort_busy", 72'(busy), 72'd0);
    chk("abort_addr", 72'(bus.mem_addr), 72'd0);
    @(posedge clk);
    #1;
    chk("abort_done", 72'(done), 72'd0);
    chk("abort_data", bus.win_data, 72'd0);
    exp_q.delete();
    rst = 1'b0;
    repeat (5) @(posedge clk);
    chk("abort_no_done", 72'(done_cnt), 72'd0);
  endtask

  initial begin
    rand_ready = 1'b0;
    spike_mode = 1'b0;
    for (int a = 0; a < NPIX; a++) img[a] = 8'(a);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 72'(busy), 72'd0);
    chk("rst_done", 72'(done), 72'd0);
    chk("rst_valid", 72'(bus.win_valid), 72'd0);
    chk("rst_addr", 72'(bus.mem_addr), 72'd0);
    chk("rst_data", bus.win_data, 72'd0);
    chk("rst_row", 72'(bus.win_row), 72'd0);
    chk("rst_col", 72'(bus.win_col), 72'd0);
    rst = 1'b0;

    // Ramp image, always ready, with a stray start pulse mid-frame.
    start_frame();
    repeat (3000) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    chk("first_latency", 72'(first_lat), 72'd406);
    chk("first_data", first_data, 72'hCA_C9_C8_66_65_64_02_01_00);
    chk("first_row", 72'(first_row), 72'd1);
    chk("first_col", 72'(first_col), 72'd1);
    chk("win_count", 72'(accepted), 72'(EXP_WIN));
    chk("busy_cycles", 72'(busy_cyc), 72'(EXP_BUSY));
    chk("done_count", 72'(done_cnt), 72'd1);
    chk("last_row", 72'(last_row), 72'(LAST_C));
    chk("last_col", 72'(last_col), 72'(LAST_C));
    chk("queue_empty", 72'(exp_q.size()), 72'd0);

    // Random backpressure, then reset after 500 accepted windows.
    rand_ready = 1'b1;
    start_frame();
    wait_accepted(500);
    abort_frame();

    // Fresh frame after the abort must start again from address 0.
    start_frame();
    wait_accepted(20);
    chk("restart_latency", 72'(first_lat), 72'd406);
    chk("restart_data", first_data, 72'hCA_C9_C8_66_65_64_02_01_00);
    chk("restart_row", 72'(first_row), 72'd1);
    chk("restart_col", 72'(first_col), 72'd1);
    abort_frame();

    // Constant image with one bright pixel at (50, 50).
    rand_ready = 1'b0;
    spike_mode = 1'b1;
    for (int a = 0; a < NPIX; a++) img[a] = 8'h7F;
    img[5050] = 8'hFF;
    start_frame();
    wait_done();
    chk("spike_win_count", 72'(accepted), 72'(EXP_WIN));
    chk("spike_busy", 72'(busy_cyc), 72'(EXP_BUSY));
    chk("spike_done_count", 72'(done_cnt), 72'd1);
    chk("spike_queue_empty", 72'(exp_q.size()), 72'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
